xbar_forward_arbiter: RTL and testbench
=======================================

Name: xbar_forward_arbiter

Overview:
Per-slave forward-path arbiter in the crossbar, one instance per outer slave. It takes the queued AR/AW/W requests that the per-master interfaces have decoded to this slave and arbitrates among masters (round-robin). It widens the IDs with the master index and drives the outer slave AXI request channels through registered output stages. The AW grant holds a W-channel lock until WLAST, so write data never interleaves.

Parameters:
ID_WIDTH, 4, master-side transaction ID width
IDS_WIDTH, 8, slave-side ID width; must be >= ID_WIDTH+$clog2(masters)
ADDR_WIDTH, 32, address width
LEN_WIDTH, 4, burst length width
SIZE_WIDTH, 3, burst size width
DATA_WIDTH, 32, data width
STRB_WIDTH, 4, strobe width
masters, 2, number of master ports; must be >= 2
slaves, 2, number of slave ports; must be >= 2
i_am_slave_number, 0, index of the slave this instance serves

Ports:
ACLK  in  1  clock
ARESETn  in  1  reset
mst_ar_empty  in  [masters] x 1  master AR queue front not presentable
mst_ar_dest  in  [masters] x $clog2(slaves)  decoded AR destination
mst_arid/araddr/arlen/arsize/arburst  in  [masters] x field widths  AR front payload
ar_accept  out  [masters] x 1  pop strobe to master m's AR queue
mst_aw_empty  in  [masters] x 1  master AW queue front not presentable
mst_aw_dest  in  [masters] x $clog2(slaves)  decoded AW destination
mst_awid/awaddr/awlen/awsize/awburst  in  [masters] x field widths  AW front payload
aw_accept  out  [masters] x 1  pop strobe to master m's AW queue
mst_w_empty  in  [masters] x 1  master W queue front not presentable
mst_w_dest  in  [masters] x $clog2(slaves)  destination of master's locked write
mst_wdata/wstrb/wlast  in  [masters] x field widths  W front payload
w_accept  out  [masters] x 1  pop strobe to master m's W queue
ARID_S,ARADDR_S,ARLEN_S,ARSIZE_S,ARBURST_S  out  IDS_WIDTH/field  outer slave AR payload
ARVALID_S out 1; ARREADY_S in 1
AWID_S,AWADDR_S,AWLEN_S,AWSIZE_S,AWBURST_S  out  IDS_WIDTH/field  outer slave AW payload
AWVALID_S out 1; AWREADY_S in 1
WDATA_S,WSTRB_S,WLAST_S  out  field widths  outer slave W payload
WVALID_S out 1; WREADY_S in 1

Behaviour:
- Reset ARESETn is synchronous, active-low; clock ACLK (rising edge).
- Reset values: all *VALID_S=0; all payload registers 0; all *_accept=0; rr_ar=rr_aw=0; w_lock=0; w_owner=0.
- AR request: req_ar[m] = ~mst_ar_empty[m] & (mst_ar_dest[m]==i_am_slave_number).
- AR stage free (ar_free) = ~ARVALID_S | ARREADY_S.
- Arbitration: if ar_free and any req, grant the first requesting m scanning rr_ar, rr_ar+1, … (mod masters).
- ar_accept is combinational, one-hot, and only asserted when a grant occurs.
- On an AR grant: load the output register; ARVALID_S<=1; rr_ar<=(g+1) mod masters.
- ARID_S = zero-extend({g[$clog2(masters)-1:0], mst_arid[g]}); the master index sits directly above the ID bits.
- No AR grant with ar_free: ARVALID_S<=0. ~ar_free: hold payload and ARVALID_S (AXI stability).
- Latency: request to ARVALID_S is 1 cycle. Throughput is 1 per cycle with ARREADY_S held high.
- AW: identical structure (req_aw, rr_aw, AWID_S widening), plus a grant requires w_lock==0.
- On an AW grant g: w_lock<=1; w_owner<=g.
- W path:
  - req_w = w_lock & ~mst_w_empty[w_owner] & (mst_w_dest[w_owner]==i_am_slave_number).
  - w_free = ~WVALID_S | WREADY_S.
  - If req_w & w_free: w_accept[w_owner]=1, load the W register, WVALID_S<=1.
  - If that beat has wlast=1: w_lock<=0.
  - Only w_owner is ever popped; no W interleaving.
- Simultaneous events:
  - The AW grant and WLAST load can never share a cycle (w_lock blocks AW).
  - The earliest next AW grant is the cycle after the WLAST beat is loaded.
  - W of the current burst may be accepted in the same cycle as its AW register load (the W register is independent).
- No requesters: accepts stay 0, pointers hold.
- Reset mid-burst: all state cleared next edge; outer VALIDs drop.

Optional Feature:
XBAR_FWD_FIXED_PRIO_EN:
- Defined: AR and AW use fixed priority (lowest master index wins); rr_ar/rr_aw are not implemented.
- Undefined: round-robin as above.
- W locking is unchanged in both builds.

Test Plan:
- Reset -> ARVALID_S=AWVALID_S=WVALID_S=0; all accepts 0; the following cycle, with no requests, all stay 0.
- Master0 AR (id 3, addr 0x0000_0040) dest=this, ARREADY_S=1 -> ar_accept[0]=1 same cycle; next cycle ARVALID_S=1, ARID_S=0x03, ARADDR_S=0x40.
- Both masters request AR continuously, ARREADY_S=1 -> grants alternate 0,1,0,1 (fixed-prio build: always 0).
- Master1 AW id 2 len 3, WREADY_S=1 -> AWID_S=0x12; 4 W beats from master1 only; a master0 AW is held until the cycle after WLAST_S is loaded, then granted.
- ARREADY_S=0 for 3 cycles with ARVALID_S=1 -> payload stable, ar_accept=0 throughout; on ARREADY_S=1 the next grant is accepted the same cycle.
- Request with dest≠i_am_slave_number -> no accept, no VALID.

Source files
------------

// File: rtl/xbar_forward_arbiter.sv
// xbar_forward_arbiter: per-slave forward-path arbiter of the crossbar.
// Arbitrates the AR and AW requests that masters have decoded to this slave,
// widens IDs with the master index and drives registered AXI request stages.
// An AW grant locks the W channel to the granted master until its WLAST beat.
// Build option: define XBAR_FWD_FIXED_PRIO_EN for fixed priority (lowest
// master index wins) instead of round-robin on AR and AW.
module xbar_forward_arbiter #(
    parameter int ID_WIDTH          = 4,
    parameter int IDS_WIDTH         = 8,
    parameter int ADDR_WIDTH        = 32,
    parameter int LEN_WIDTH         = 4,
    parameter int SIZE_WIDTH        = 3,
    parameter int DATA_WIDTH        = 32,
    parameter int STRB_WIDTH        = 4,
    parameter int masters           = 2,
    parameter int slaves            = 2,
    parameter int i_am_slave_number = 0,
    localparam int MW = $clog2(masters),
    localparam int SW = $clog2(slaves)
) (
    input  logic                                  ACLK,
    input  logic                                  ARESETn,
    input  logic [masters-1:0]                    mst_ar_empty,
    input  logic [masters-1:0][SW-1:0]            mst_ar_dest,
    input  logic [masters-1:0][ID_WIDTH-1:0]      mst_arid,
    input  logic [masters-1:0][ADDR_WIDTH-1:0]    mst_araddr,
    input  logic [masters-1:0][LEN_WIDTH-1:0]     mst_arlen,
    input  logic [masters-1:0][SIZE_WIDTH-1:0]    mst_arsize,
    input  logic [masters-1:0][1:0]               mst_arburst,
    output logic [masters-1:0]                    ar_accept,
    input  logic [masters-1:0]                    mst_aw_empty,
    input  logic [masters-1:0][SW-1:0]            mst_aw_dest,
    input  logic [masters-1:0][ID_WIDTH-1:0]      mst_awid,
    input  logic [masters-1:0][ADDR_WIDTH-1:0]    mst_awaddr,
    input  logic [masters-1:0][LEN_WIDTH-1:0]     mst_awlen,
    input  logic [masters-1:0][SIZE_WIDTH-1:0]    mst_awsize,
    input  logic [masters-1:0][1:0]               mst_awburst,
    output logic [masters-1:0]                    aw_accept,
    input  logic [masters-1:0]                    mst_w_empty,
    input  logic [masters-1:0][SW-1:0]            mst_w_dest,
    input  logic [masters-1:0][DATA_WIDTH-1:0]    mst_wdata,
    input  logic [masters-1:0][STRB_WIDTH-1:0]    mst_wstrb,
    input  logic [masters-1:0]                    mst_wlast,
    output logic [masters-1:0]                    w_accept,
    output logic [IDS_WIDTH-1:0]                  ARID_S,
    output logic [ADDR_WIDTH-1:0]                 ARADDR_S,
    output logic [LEN_WIDTH-1:0]                  ARLEN_S,
    output logic [SIZE_WIDTH-1:0]                 ARSIZE_S,
    output logic [1:0]                            ARBURST_S,
    output logic                                  ARVALID_S,
    input  logic                                  ARREADY_S,
    output logic [IDS_WIDTH-1:0]                  AWID_S,
    output logic [ADDR_WIDTH-1:0]                 AWADDR_S,
    output logic [LEN_WIDTH-1:0]                  AWLEN_S,
    output logic [SIZE_WIDTH-1:0]                 AWSIZE_S,
    output logic [1:0]                            AWBURST_S,
    output logic                                  AWVALID_S,
    input  logic                                  AWREADY_S,
    output logic [DATA_WIDTH-1:0]                 WDATA_S,
    output logic [STRB_WIDTH-1:0]                 WSTRB_S,
    output logic                                  WLAST_S,
    output logic                                  WVALID_S,
    input  logic                                  WREADY_S
);

    localparam logic [SW-1:0] MY_SLV = SW'(i_am_slave_number);

    // Returns {found, index} of the first requester scanning start, start+1, ...
    function automatic logic [MW:0] rr_pick(input logic [masters-1:0] req, input int start);
        logic [MW:0]   res;
        logic [MW-1:0] idx;
        res = '0;
        for (int k = masters - 1; k >= 0; k--) begin
            idx = MW'((start + k) % masters);
            if (req[idx]) res = {1'b1, idx};
        end
        return res;
    endfunction

    logic                  ar_valid_q, ar_valid_d, aw_valid_q, aw_valid_d, w_valid_q, w_valid_d;
    logic [IDS_WIDTH-1:0]  ar_id_q, ar_id_d, aw_id_q, aw_id_d;
    logic [ADDR_WIDTH-1:0] ar_addr_q, ar_addr_d, aw_addr_q, aw_addr_d;
    logic [LEN_WIDTH-1:0]  ar_len_q, ar_len_d, aw_len_q, aw_len_d;
    logic [SIZE_WIDTH-1:0] ar_size_q, ar_size_d, aw_size_q, aw_size_d;
    logic [1:0]            ar_burst_q, ar_burst_d, aw_burst_q, aw_burst_d;
    logic [DATA_WIDTH-1:0] w_data_q, w_data_d;
    logic [STRB_WIDTH-1:0] w_strb_q, w_strb_d;
    logic                  w_last_q, w_last_d, w_lock_q, w_lock_d;
    logic [MW-1:0]         w_owner_q, w_owner_d;
    logic [MW-1:0]         rr_ar_q, rr_ar_d, rr_aw_q, rr_aw_d;
    logic [masters-1:0]    req_ar, req_aw;
    logic [MW:0]           ar_pick, aw_pick;
    logic [MW-1:0]         ar_idx, aw_idx;
    logic                  ar_grant, aw_grant, req_w, w_go;
    int                    ar_start, aw_start;

    // Arbitration, accept strobes and next state of all output stages
    always_comb begin
        for (int m = 0; m < masters; m++) begin
            req_ar[m] = ~mst_ar_empty[m] & (mst_ar_dest[m] == MY_SLV);
            req_aw[m] = ~mst_aw_empty[m] & (mst_aw_dest[m] == MY_SLV);
        end
`ifdef XBAR_FWD_FIXED_PRIO_EN
        ar_start = 0;
        aw_start = 0;
`else
        ar_start = int'(rr_ar_q);
        aw_start = int'(rr_aw_q);
`endif
        ar_pick  = rr_pick(req_ar, ar_start);
        aw_pick  = rr_pick(req_aw, aw_start);
        ar_idx   = ar_pick[MW-1:0];
        aw_idx   = aw_pick[MW-1:0];
        ar_grant = ARESETn & ar_pick[MW] & (~ar_valid_q | ARREADY_S);
        aw_grant = ARESETn & aw_pick[MW] & (~aw_valid_q | AWREADY_S) & ~w_lock_q;
        req_w    = w_lock_q & ~mst_w_empty[w_owner_q] & (mst_w_dest[w_owner_q] == MY_SLV);
        w_go     = ARESETn & req_w & (~w_valid_q | WREADY_S);

        ar_accept = '0;
        aw_accept = '0;
        w_accept  = '0;
        if (ar_grant) ar_accept[ar_idx] = 1'b1;
        if (aw_grant) aw_accept[aw_idx] = 1'b1;
        if (w_go)     w_accept[w_owner_q] = 1'b1;

        ar_valid_d = ar_valid_q;
        ar_id_d    = ar_id_q;
        ar_addr_d  = ar_addr_q;
        ar_len_d   = ar_len_q;
        ar_size_d  = ar_size_q;
        ar_burst_d = ar_burst_q;
        rr_ar_d    = rr_ar_q;
        if (ar_grant) begin
            ar_valid_d = 1'b1;
            ar_id_d    = IDS_WIDTH'({ar_idx, mst_arid[ar_idx]});
            ar_addr_d  = mst_araddr[ar_idx];
            ar_len_d   = mst_arlen[ar_idx];
            ar_size_d  = mst_arsize[ar_idx];
            ar_burst_d = mst_arburst[ar_idx];
            rr_ar_d    = MW'((int'(ar_idx) + 1) % masters);
        end else if (~ar_valid_q | ARREADY_S) begin
            ar_valid_d = 1'b0;
        end

        aw_valid_d = aw_valid_q;
        aw_id_d    = aw_id_q;
        aw_addr_d  = aw_addr_q;
        aw_len_d   = aw_len_q;
        aw_size_d  = aw_size_q;
        aw_burst_d = aw_burst_q;
        rr_aw_d    = rr_aw_q;
        w_lock_d   = w_lock_q;
        w_owner_d  = w_owner_q;
        if (aw_grant) begin
            aw_valid_d = 1'b1;
            aw_id_d    = IDS_WIDTH'({aw_idx, mst_awid[aw_idx]});
            aw_addr_d  = mst_awaddr[aw_idx];
            aw_len_d   = mst_awlen[aw_idx];
            aw_size_d  = mst_awsize[aw_idx];
            aw_burst_d = mst_awburst[aw_idx];
            rr_aw_d    = MW'((int'(aw_idx) + 1) % masters);
            w_lock_d   = 1'b1;
            w_owner_d  = aw_idx;
        end else if (~aw_valid_q | AWREADY_S) begin
            aw_valid_d = 1'b0;
        end

        w_valid_d = w_valid_q;
        w_data_d  = w_data_q;
        w_strb_d  = w_strb_q;
        w_last_d  = w_last_q;
        if (w_go) begin
            w_valid_d = 1'b1;
            w_data_d  = mst_wdata[w_owner_q];
            w_strb_d  = mst_wstrb[w_owner_q];
            w_last_d  = mst_wlast[w_owner_q];
            if (mst_wlast[w_owner_q]) w_lock_d = 1'b0;
        end else if (~w_valid_q | WREADY_S) begin
            w_valid_d = 1'b0;
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            ar_valid_q <= 1'b0; ar_id_q <= '0; ar_addr_q <= '0;
            ar_len_q   <= '0;   ar_size_q <= '0; ar_burst_q <= '0;
            aw_valid_q <= 1'b0; aw_id_q <= '0; aw_addr_q <= '0;
            aw_len_q   <= '0;   aw_size_q <= '0; aw_burst_q <= '0;
            w_valid_q  <= 1'b0; w_data_q <= '0; w_strb_q <= '0; w_last_q <= 1'b0;
            w_lock_q   <= 1'b0; w_owner_q <= '0;
        end else begin
            ar_valid_q <= ar_valid_d; ar_id_q <= ar_id_d; ar_addr_q <= ar_addr_d;
            ar_len_q   <= ar_len_d;   ar_size_q <= ar_size_d; ar_burst_q <= ar_burst_d;
            aw_valid_q <= aw_valid_d; aw_id_q <= aw_id_d; aw_addr_q <= aw_addr_d;
            aw_len_q   <= aw_len_d;   aw_size_q <= aw_size_d; aw_burst_q <= aw_burst_d;
            w_valid_q  <= w_valid_d;  w_data_q <= w_data_d; w_strb_q <= w_strb_d; w_last_q <= w_last_d;
            w_lock_q   <= w_lock_d;   w_owner_q <= w_owner_d;
        end
    end

`ifdef XBAR_FWD_FIXED_PRIO_EN
    assign rr_ar_q = '0;
    assign rr_aw_q = '0;
`else
    // Round-robin pointers
    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            rr_ar_q <= '0;
            rr_aw_q <= '0;
        end else begin
            rr_ar_q <= rr_ar_d;
            rr_aw_q <= rr_aw_d;
        end
    end
`endif

    assign ARVALID_S = ar_valid_q;
    assign ARID_S    = ar_id_q;
    assign ARADDR_S  = ar_addr_q;
    assign ARLEN_S   = ar_len_q;
    assign ARSIZE_S  = ar_size_q;
    assign ARBURST_S = ar_burst_q;
    assign AWVALID_S = aw_valid_q;
    assign AWID_S    = aw_id_q;
    assign AWADDR_S  = aw_addr_q;
    assign AWLEN_S   = aw_len_q;
    assign AWSIZE_S  = aw_size_q;
    assign AWBURST_S = aw_burst_q;
    assign WVALID_S  = w_valid_q;
    assign WDATA_S   = w_data_q;
    assign WSTRB_S   = w_strb_q;
    assign WLAST_S   = w_last_q;

endmodule

// File: tb/tb_xbar_forward_arbiter.sv
// Testbench for xbar_forward_arbiter: directed scenarios plus randomized
// traffic, all checked every cycle against a transaction-level model.
module tb_xbar_forward_arbiter;
    localparam int M = 2;
    localparam int SLV = 0;
    localparam int IDW = 4;

    logic ACLK, ARESETn;
    logic [M-1:0]        mst_ar_empty, mst_aw_empty, mst_w_empty, mst_wlast;
    logic [M-1:0][0:0]   mst_ar_dest, mst_aw_dest, mst_w_dest;
    logic [M-1:0][3:0]   mst_arid, mst_awid, mst_arlen, mst_awlen, mst_wstrb;
    logic [M-1:0][31:0]  mst_araddr, mst_awaddr, mst_wdata;
    logic [M-1:0][2:0]   mst_arsize, mst_awsize;
    logic [M-1:0][1:0]   mst_arburst, mst_awburst;
    logic [M-1:0]        ar_accept, aw_accept, w_accept;
    logic [7:0]  ARID_S, AWID_S;
    logic [31:0] ARADDR_S, AWADDR_S, WDATA_S;
    logic [3:0]  ARLEN_S, AWLEN_S, WSTRB_S;
    logic [2:0]  ARSIZE_S, AWSIZE_S;
    logic [1:0]  ARBURST_S, AWBURST_S;
    logic ARVALID_S, ARREADY_S, AWVALID_S, AWREADY_S, WVALID_S, WREADY_S, WLAST_S;

    xbar_forward_arbiter #(.masters(M), .slaves(2), .i_am_slave_number(SLV)) dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .mst_ar_empty(mst_ar_empty), .mst_ar_dest(mst_ar_dest), .mst_arid(mst_arid),
        .mst_araddr(mst_araddr), .mst_arlen(mst_arlen), .mst_arsize(mst_arsize),
        .mst_arburst(mst_arburst), .ar_accept(ar_accept),
        .mst_aw_empty(mst_aw_empty), .mst_aw_dest(mst_aw_dest), .mst_awid(mst_awid),
        .mst_awaddr(mst_awaddr), .mst_awlen(mst_awlen), .mst_awsize(mst_awsize),
        .mst_awburst(mst_awburst), .aw_accept(aw_accept),
        .mst_w_empty(mst_w_empty), .mst_w_dest(mst_w_dest), .mst_wdata(mst_wdata),
        .mst_wstrb(mst_wstrb), .mst_wlast(mst_wlast), .w_accept(w_accept),
        .ARID_S(ARID_S), .ARADDR_S(ARADDR_S), .ARLEN_S(ARLEN_S), .ARSIZE_S(ARSIZE_S),
        .ARBURST_S(ARBURST_S), .ARVALID_S(ARVALID_S), .ARREADY_S(ARREADY_S),
        .AWID_S(AWID_S), .AWADDR_S(AWADDR_S), .AWLEN_S(AWLEN_S), .AWSIZE_S(AWSIZE_S),
        .AWBURST_S(AWBURST_S), .AWVALID_S(AWVALID_S), .AWREADY_S(AWREADY_S),
        .WDATA_S(WDATA_S), .WSTRB_S(WSTRB_S), .WLAST_S(WLAST_S),
        .WVALID_S(WVALID_S), .WREADY_S(WREADY_S)
    );

    initial begin
        ACLK = 0;
        forever #5 ACLK = ~ACLK;
    end

    int n_checks = 0;
    int n_fail = 0;

    // Reference model state: what the outer slave channels should show
    logic        m_arv, m_awv, m_wv, m_wlast, m_lock;
    logic [7:0]  m_arid, m_awid;
    logic [31:0] m_araddr, m_awaddr, m_wdata;
    logic [3:0]  m_arlen, m_awlen, m_wstrb;
    logic [2:0]  m_arsize, m_awsize;
    logic [1:0]  m_arburst, m_awburst;
    int          m_rr_ar, m_rr_aw, m_owner;
    logic [M-1:0] last_ar_acc, last_aw_acc, last_w_acc;

    function automatic int pick(input logic [M-1:0] req, input int start);
`ifdef XBAR_FWD_FIXED_PRIO_EN
        start = 0;
`endif
        for (int k = 0; k < M; k++)
            if (req[(start + k) % M]) return (start + k) % M;
        return -1;
    endfunction

    task automatic model_clear();
        m_arv = 0; m_awv = 0; m_wv = 0; m_wlast = 0; m_lock = 0;
        m_arid = 0; m_awid = 0; m_araddr = 0; m_awaddr = 0; m_wdata = 0;
        m_arlen = 0; m_awlen = 0; m_wstrb = 0; m_arsize = 0; m_awsize = 0;
        m_arburst = 0; m_awburst = 0; m_rr_ar = 0; m_rr_aw = 0; m_owner = 0;
    endtask

    // One clock: check accept strobes before the edge, registered outputs after
    task automatic step();
        int gar, gaw;
        logic wgo;
        logic [M-1:0] rq_ar, rq_aw, e_ar, e_aw, e_w;
        #1;
        gar = -1; gaw = -1; wgo = 0; e_ar = 0; e_aw = 0; e_w = 0;
        for (int m = 0; m < M; m++) begin
            rq_ar[m] = !mst_ar_empty[m] && int'(mst_ar_dest[m]) == SLV;
            rq_aw[m] = !mst_aw_empty[m] && int'(mst_aw_dest[m]) == SLV;
        end
        if (ARESETn) begin
            if (!m_arv || ARREADY_S) gar = pick(rq_ar, m_rr_ar);
            if ((!m_awv || AWREADY_S) && !m_lock) gaw = pick(rq_aw, m_rr_aw);
            wgo = m_lock && !mst_w_empty[m_owner] && int'(mst_w_dest[m_owner]) == SLV
                  && (!m_wv || WREADY_S);
        end
        if (gar >= 0) e_ar[gar] = 1;
        if (gaw >= 0) e_aw[gaw] = 1;
        if (wgo) e_w[m_owner] = 1;
        n_checks++;
        if (ar_accept !== e_ar) begin n_fail++; $display("FAIL ar_accept got %b want %b t=%0t", ar_accept, e_ar, $time); end
        n_checks++;
        if (aw_accept !== e_aw) begin n_fail++; $display("FAIL aw_accept got %b want %b t=%0t", aw_accept, e_aw, $time); end
        n_checks++;
        if (w_accept !== e_w) begin n_fail++; $display("FAIL w_accept got %b want %b t=%0t", w_accept, e_w, $time); end
        last_ar_acc = ar_accept; last_aw_acc = aw_accept; last_w_acc = w_accept;
        @(posedge ACLK);
        if (!ARESETn) begin
            model_clear();
        end else begin
            if (gar >= 0) begin
                m_arv = 1; m_arid = 8'(gar * (1 << IDW) + int'(mst_arid[gar]));
                m_araddr = mst_araddr[gar]; m_arlen = mst_arlen[gar];
                m_arsize = mst_arsize[gar]; m_arburst = mst_arburst[gar];
                m_rr_ar = (gar + 1) % M;
            end else if (ARREADY_S) m_arv = 0;
            if (gaw >= 0) begin
                m_awv = 1; m_awid = 8'(gaw * (1 << IDW) + int'(mst_awid[gaw]));
                m_awaddr = mst_awaddr[gaw]; m_awlen = mst_awlen[gaw];
                m_awsize = mst_awsize[gaw]; m_awburst = mst_awburst[gaw];
                m_rr_aw = (gaw + 1) % M;
                m_lock = 1; m_owner = gaw;
            end else if (AWREADY_S) m_awv = 0;
            if (wgo) begin
                m_wv = 1; m_wdata = mst_wdata[m_owner]; m_wstrb = mst_wstrb[m_owner];
                m_wlast = mst_wlast[m_owner];
                if (mst_wlast[m_owner]) m_lock = 0;
            end else if (WREADY_S) m_wv = 0;
        end
        #1;
        n_checks++;
        if ({ARVALID_S, ARID_S, ARADDR_S, ARLEN_S, ARSIZE_S, ARBURST_S} !==
            {m_arv, m_arid, m_araddr, m_arlen, m_arsize, m_arburst}) begin
            n_fail++;
            $display("FAIL ar_chan got v=%b id=%h a=%h l=%h s=%h b=%h want v=%b id=%h a=%h l=%h s=%h b=%h t=%0t",
                ARVALID_S, ARID_S, ARADDR_S, ARLEN_S, ARSIZE_S, ARBURST_S,
                m_arv, m_arid, m_araddr, m_arlen, m_arsize, m_arburst, $time);
        end
        n_checks++;
        if ({AWVALID_S, AWID_S, AWADDR_S, AWLEN_S, AWSIZE_S, AWBURST_S} !==
            {m_awv, m_awid, m_awaddr, m_awlen, m_awsize, m_awburst}) begin
            n_fail++;
            $display("FAIL aw_chan got v=%b id=%h a=%h l=%h s=%h b=%h want v=%b id=%h a=%h l=%h s=%h b=%h t=%0t",
                AWVALID_S, AWID_S, AWADDR_S, AWLEN_S, AWSIZE_S, AWBURST_S,
                m_awv, m_awid, m_awaddr, m_awlen, m_awsize, m_awburst, $time);
        end
        n_checks++;
        if ({WVALID_S, WDATA_S, WSTRB_S, WLAST_S} !== {m_wv, m_wdata, m_wstrb, m_wlast}) begin
            n_fail++;
            $display("FAIL w_chan got v=%b d=%h s=%h l=%b want v=%b d=%h s=%h l=%b t=%0t",
                WVALID_S, WDATA_S, WSTRB_S, WLAST_S, m_wv, m_wdata, m_wstrb, m_wlast, $time);
        end
    endtask

    task automatic idle();
        mst_ar_empty = '1; mst_aw_empty = '1; mst_w_empty = '1; mst_wlast = '0;
        mst_ar_dest = '0; mst_aw_dest = '0; mst_w_dest = '0;
        mst_arid = '0; mst_awid = '0; mst_arlen = '0; mst_awlen = '0; mst_wstrb = '0;
        mst_araddr = '0; mst_awaddr = '0; mst_wdata = '0;
        mst_arsize = '0; mst_awsize = '0; mst_arburst = '0; mst_awburst = '0;
        ARREADY_S = 1; AWREADY_S = 1; WREADY_S = 1;
    endtask

    task automatic do_reset();
        idle();
        ARESETn = 0;
        step();
        ARESETn = 1;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if ({ARVALID_S, AWVALID_S, WVALID_S, ar_accept, aw_accept, w_accept} !== 9'b0) begin
            n_fail++; $display("FAIL reset_state got %b want 0", {ARVALID_S, AWVALID_S, WVALID_S, ar_accept, aw_accept, w_accept});
        end
        step();
        n_checks++;
        if ({ARVALID_S, AWVALID_S, WVALID_S, last_ar_acc, last_aw_acc, last_w_acc} !== 9'b0) begin
            n_fail++; $display("FAIL idle_after_reset got %b want 0", {ARVALID_S, AWVALID_S, WVALID_S, last_ar_acc, last_aw_acc, last_w_acc});
        end
    endtask

    task automatic test_ar_single();
        do_reset();
        mst_ar_empty[0] = 0; mst_arid[0] = 4'h3; mst_araddr[0] = 32'h0000_0040;
        step();
        n_checks++;
        if (last_ar_acc !== 2'b01) begin n_fail++; $display("FAIL ar_single_accept got %b want 01", last_ar_acc); end
        n_checks++;
        if ({ARVALID_S, ARID_S, ARADDR_S} !== {1'b1, 8'h03, 32'h40}) begin
            n_fail++; $display("FAIL ar_single_out got v=%b id=%h a=%h want v=1 id=03 a=40", ARVALID_S, ARID_S, ARADDR_S);
        end
        mst_ar_empty[0] = 1;
        step();
    endtask

    task automatic test_ar_round_robin();
        logic [M-1:0] exp;
        do_reset();
        mst_ar_empty = '0; mst_arid[0] = 4'h1; mst_arid[1] = 4'h5;
        for (int i = 0; i < 6; i++) begin
            step();
`ifdef XBAR_FWD_FIXED_PRIO_EN
            exp = 2'b01;
`else
            exp = (i % 2 == 0) ? 2'b01 : 2'b10;
`endif
            n_checks++;
            if (last_ar_acc !== exp) begin n_fail++; $display("FAIL ar_rr_grant%0d got %b want %b", i, last_ar_acc, exp); end
        end
        mst_ar_empty = '1;
        step();
    endtask

    task automatic test_aw_w_lock();
        do_reset();
        mst_aw_empty[1] = 0; mst_awid[1] = 4'h2; mst_awlen[1] = 4'd3; mst_awaddr[1] = 32'h1000;
        mst_w_empty = '0; mst_wdata[0] = 32'hDEAD_0000;
        step();
        n_checks++;
        if ({last_aw_acc, AWVALID_S, AWID_S} !== {2'b10, 1'b1, 8'h12}) begin
            n_fail++; $display("FAIL aw_grant got acc=%b v=%b id=%h want acc=10 v=1 id=12", last_aw_acc, AWVALID_S, AWID_S);
        end
        mst_aw_empty[1] = 1;
        mst_aw_empty[0] = 0; mst_awid[0] = 4'h7; mst_awaddr[0] = 32'h2000;
        for (int k = 0; k < 4; k++) begin
            mst_wdata[1] = 32'hA0 + 32'(k); mst_wlast[1] = (k == 3);
            step();
            n_checks++;
            if ({last_w_acc, last_aw_acc} !== 4'b1000) begin
                n_fail++; $display("FAIL w_beat%0d got w=%b aw=%b want w=10 aw=00", k, last_w_acc, last_aw_acc);
            end
        end
        n_checks++;
        if ({WVALID_S, WLAST_S, WDATA_S} !== {2'b11, 32'hA3}) begin
            n_fail++; $display("FAIL w_last_beat got v=%b l=%b d=%h want v=1 l=1 d=a3", WVALID_S, WLAST_S, WDATA_S);
        end
        mst_w_empty[1] = 1;
        step();
        n_checks++;
        if ({last_aw_acc, AWID_S} !== {2'b01, 8'h07}) begin
            n_fail++; $display("FAIL aw_after_wlast got acc=%b id=%h want acc=01 id=07", last_aw_acc, AWID_S);
        end
        idle();
        for (int i = 0; i < 3; i++) step();
    endtask

    task automatic test_ar_stall();
        do_reset();
        ARREADY_S = 0;
        mst_ar_empty[0] = 0; mst_araddr[0] = 32'h100;
        step();
        mst_araddr[0] = 32'h200;
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++;
            if ({last_ar_acc, ARVALID_S, ARADDR_S} !== {2'b00, 1'b1, 32'h100}) begin
                n_fail++; $display("FAIL ar_stall%0d got acc=%b v=%b a=%h want acc=00 v=1 a=100", i, last_ar_acc, ARVALID_S, ARADDR_S);
            end
        end
        ARREADY_S = 1;
        step();
        n_checks++;
        if ({last_ar_acc, ARADDR_S} !== {2'b01, 32'h200}) begin
            n_fail++; $display("FAIL ar_release got acc=%b a=%h want acc=01 a=200", last_ar_acc, ARADDR_S);
        end
        idle();
        step();
    endtask

    task automatic test_dest_filter();
        do_reset();
        mst_ar_empty = '0; mst_aw_empty = '0; mst_w_empty = '0;
        mst_ar_dest = '1; mst_aw_dest = '1; mst_w_dest = '1;
        for (int i = 0; i < 2; i++) begin
            step();
            n_checks++;
            if ({last_ar_acc, last_aw_acc, last_w_acc, ARVALID_S, AWVALID_S, WVALID_S} !== 9'b0) begin
                n_fail++; $display("FAIL dest_filter%0d got %b want 0", i,
                    {last_ar_acc, last_aw_acc, last_w_acc, ARVALID_S, AWVALID_S, WVALID_S});
            end
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 2000; c++) begin
            for (int m = 0; m < M; m++) begin
                mst_ar_empty[m] = ($urandom_range(0, 2) == 0);
                mst_aw_empty[m] = ($urandom_range(0, 2) == 0);
                mst_w_empty[m]  = ($urandom_range(0, 3) == 0);
                mst_ar_dest[m]  = ($urandom_range(0, 3) == 0);
                mst_aw_dest[m]  = ($urandom_range(0, 3) == 0);
                mst_w_dest[m]   = ($urandom_range(0, 7) == 0);
                mst_arid[m] = 4'($urandom); mst_awid[m] = 4'($urandom);
                mst_araddr[m] = $urandom; mst_awaddr[m] = $urandom; mst_wdata[m] = $urandom;
                mst_arlen[m] = 4'($urandom); mst_awlen[m] = 4'($urandom); mst_wstrb[m] = 4'($urandom);
                mst_arsize[m] = 3'($urandom); mst_awsize[m] = 3'($urandom);
                mst_arburst[m] = 2'($urandom); mst_awburst[m] = 2'($urandom);
                mst_wlast[m] = ($urandom_range(0, 3) == 0);
            end
            ARREADY_S = ($urandom_range(0, 3) != 0);
            AWREADY_S = ($urandom_range(0, 3) != 0);
            WREADY_S  = ($urandom_range(0, 3) != 0);
            ARESETn   = ($urandom_range(0, 249) != 0);
            step();
        end
        ARESETn = 1;
    endtask

    initial begin
        model_clear();
        idle();
        ARESETn = 0;
        test_reset();
        test_ar_single();
        test_ar_round_robin();
        test_aw_w_lock();
        test_ar_stall();
        test_dest_filter();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
